// File: rtl/uart_rfifo_ctrl.sv
// Receive-FIFO control for a 16550-style UART: push/pop/flush strobes,
// trigger-level and character-timeout interrupts, and line-status flags.
module uart_rfifo_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int COUNT_W    = 5
) (
    input  logic               clk,
    input  logic               wb_rst_i,
    input  logic               rx_valid,
    input  logic               rbr_rd,
    input  logic               lsr_rd,
    input  logic               fcr_wr,
    input  logic [7:0]         fcr_din,
    input  logic [3:0]         lcr,
    input  logic               bit_tick,
    input  logic [COUNT_W-1:0] fifo_count,
    input  logic               fifo_overrun,
    input  logic               fifo_error_bit,
    output logic               rfifo_push,
    output logic               rfifo_pop,
    output logic               rfifo_reset,
    output logic               rfifo_reset_status,
    output logic               rda_int,
    output logic               cti_int,
    output logic               rls_int,
    output logic               lsr_dr
);

    localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(FIFO_DEPTH);

    logic               flush_req;
    logic               fifo_nonempty;
    logic               pop_q;
    logic [1:0]         trig_q;
    logic [COUNT_W-1:0] trig_level;
    logic [3:0]         char_bits;
    logic [5:0]         tmo_limit;
    logic [5:0]         tmo_cnt;
    logic [5:0]         tmo_next;
    logic               tmo_clear;
    logic               tmo_at_limit;

    assign flush_req     = fcr_wr & fcr_din[1];
    assign fifo_nonempty = (fifo_count != '0);

    // A flush in the same cycle wins over an incoming character.
    assign rfifo_push = rx_valid & ~flush_req;
    assign rfifo_pop  = pop_q & ~rfifo_reset;

    // Trigger decode; clamped so a shallow FIFO can still raise rda_int.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        trig_level = COUNT_W'(1);
        case (trig_q)
            2'b00:   trig_level = COUNT_W'(1);
            2'b01:   trig_level = COUNT_W'(4);
            2'b10:   trig_level = COUNT_W'(8);
            default: trig_level = COUNT_W'(14);
        endcase
        if (trig_level > DEPTH_C) begin
            trig_level = DEPTH_C;
        end
    end

    // Start bit + data bits + optional parity + stop bit(s), four character times.
    assign char_bits = 4'd7 + {2'b00, lcr[1:0]} + {3'b000, lcr[3]} + {3'b000, lcr[2]};
    assign tmo_limit = {char_bits, 2'b00};

    // ">=" so a counter stranded above a freshly shortened limit counts as expired.
    assign tmo_at_limit = (tmo_cnt >= tmo_limit);
    assign tmo_clear    = rfifo_push | rfifo_pop | rfifo_reset | ~fifo_nonempty;

    always_comb begin
        tmo_next = tmo_cnt;
        if (tmo_clear) begin
            tmo_next = '0;
        end else if (bit_tick && !tmo_at_limit) begin
            tmo_next = tmo_cnt + 6'd1;
        end
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            pop_q              <= 1'b0;
            rfifo_reset        <= 1'b0;
            rfifo_reset_status <= 1'b0;
            trig_q             <= 2'b00;
            tmo_cnt            <= '0;
            rda_int            <= 1'b0;
            cti_int            <= 1'b0;
            rls_int            <= 1'b0;
            lsr_dr             <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            pop_q              <= rbr_rd & fifo_nonempty;
            rfifo_reset        <= flush_req;
            rfifo_reset_status <= lsr_rd;
            if (fcr_wr) begin
                trig_q <= fcr_din[7:6];
            end
            tmo_cnt <= tmo_next;
            rda_int <= (fifo_count >= trig_level);
            cti_int <= ~tmo_clear & tmo_at_limit & fifo_nonempty;
            rls_int <= fifo_overrun | fifo_error_bit;
            lsr_dr  <= fifo_nonempty;
        end
    end

endmodule
